// File: rtl/adc_resp_pkg.sv
// Shared types and sizes for the MCP3002-style SPI responder.
package adc_resp_pkg;

  localparam int ADC_BITS  = 10;
  localparam int CFG_BITS  = 3;
  localparam int LSBF_BITS = 9;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CFG,
    ST_NULL,
    ST_DATA,
    ST_LSBF,
    ST_DONE
  } state_e;

  // States in which an early CS release truncates a frame.
  function automatic logic is_abortable(input state_e s);
    return s inside {ST_WAIT_START, ST_CFG, ST_NULL, ST_DATA};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchronizer with registered rise/fall pulses for one asynchronous pin.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: the chain resets to the pin's idle level so that reset release
  // with the pin idle never produces a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 10-bit, 2-channel MCP3002 ADC on an oversampling clock.
// Define ADC_RESP_LSBF_EN to append the LSB-first tail on MSBF=0 frames.
module adc_spi_responder
  import adc_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                adc_sck,
  input  logic                adc_cs,
  input  logic                sdata_to_adc,
  output logic                sdata_from_adc,
  output logic                sdo_oe,
  input  logic [ADC_BITS-1:0] sample_ch0,
  input  logic [ADC_BITS-1:0] sample_ch1,
  output logic                sample_strobe,
  output logic                channel,
  output logic                sgl_diff,
  output logic                busy,
  output logic                abort
);

  logic sck_rise, sck_fall, cs_rise, cs_fall, sdi;
  logic [SYNC_STAGES-1:0] sdi_sync_q;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_det (
    .clk(sysclk), .rst_n(rst_n), .din(adc_sck), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_det (
    .clk(sysclk), .rst_n(rst_n), .din(adc_cs), .rise(cs_rise), .fall(cs_fall)
  );

  // SDI is read one cycle after the edge pulse, so the plain chain lines up with it.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) sdi_sync_q <= '0;
    else        sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdata_to_adc};
  end
  assign sdi = sdi_sync_q[SYNC_STAGES-1];

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADC_BITS-1:0] shreg_q, shreg_d;
  logic                sgl_cap_q, sgl_cap_d, odd_cap_q, odd_cap_d;
  logic                sdo_d, oe_d, strobe_d, chan_d, sgl_d, busy_d, abort_d;
`ifdef ADC_RESP_LSBF_EN
  logic                msbf_q, msbf_d;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      shreg_q        <= '0;
      sgl_cap_q      <= 1'b0;
      odd_cap_q      <= 1'b0;
      sdata_from_adc <= 1'b0;
      sdo_oe         <= 1'b0;
      sample_strobe  <= 1'b0;
      channel        <= 1'b0;
      sgl_diff       <= 1'b0;
      busy           <= 1'b0;
      abort          <= 1'b0;
`ifdef ADC_RESP_LSBF_EN
      msbf_q         <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      sgl_cap_q      <= sgl_cap_d;
      odd_cap_q      <= odd_cap_d;
      sdata_from_adc <= sdo_d;
      sdo_oe         <= oe_d;
      sample_strobe  <= strobe_d;
      channel        <= chan_d;
      sgl_diff       <= sgl_d;
      busy           <= busy_d;
      abort          <= abort_d;
`ifdef ADC_RESP_LSBF_EN
      msbf_q         <= msbf_d;
`endif
    end
  end

  // NOTE: every target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    sgl_cap_d = sgl_cap_q;
    odd_cap_d = odd_cap_q;
    sdo_d     = sdata_from_adc;
    oe_d      = sdo_oe;
    strobe_d  = 1'b0;
    chan_d    = channel;
    sgl_d     = sgl_diff;
    busy_d    = busy;
    abort_d   = 1'b0;
`ifdef ADC_RESP_LSBF_EN
    msbf_d    = msbf_q;
`endif

    // A CS release outranks any SCK edge seen in the same cycle.
    if (cs_rise && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      sdo_d   = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      abort_d = is_abortable(state_q);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sdo_d = 1'b0;
          oe_d  = 1'b0;
          if (cs_fall) begin
            state_d = ST_WAIT_START;
            busy_d  = 1'b1;
          end
        end
        ST_WAIT_START: if (sck_rise && sdi) begin
          state_d = ST_CFG;
          cnt_d   = '0;
        end
        ST_CFG: if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            sgl_cap_d = sdi;
          end else if (cnt_q == CNT_W'(CFG_BITS - 2)) begin
            odd_cap_d = sdi;
          end else begin
`ifdef ADC_RESP_LSBF_EN
            msbf_d = sdi;
`endif
            shreg_d  = odd_cap_q ? sample_ch1 : sample_ch0;
            strobe_d = 1'b1;
            chan_d   = odd_cap_q;
            sgl_d    = sgl_cap_q;
            state_d  = ST_NULL;
          end
        end
        ST_NULL: if (sck_fall) begin
          sdo_d   = 1'b0;
          oe_d    = 1'b1;
          cnt_d   = CNT_W'(ADC_BITS - 1);
          state_d = ST_DATA;
        end
        // Rotating keeps the sample intact for the LSB-first replay.
        ST_DATA: if (sck_fall) begin
          sdo_d   = shreg_q[ADC_BITS-1];
          shreg_d = {shreg_q[ADC_BITS-2:0], shreg_q[ADC_BITS-1]};
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
`ifdef ADC_RESP_LSBF_EN
            if (!msbf_q) begin
              state_d = ST_LSBF;
              cnt_d   = CNT_W'(LSBF_BITS - 1);
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end
        ST_LSBF: if (sck_fall) begin
          sdo_d   = shreg_q[1];
          shreg_d = {shreg_q[0], shreg_q[ADC_BITS-1:1]};
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = ST_DONE;
        end
        ST_DONE: if (sck_fall) sdo_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench: an initiator model clocks frames, a monitor compares captured frames.
module tb_adc_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       adc_sck = 1'b0, adc_cs = 1'b1, sdata_to_adc = 1'b0;
  logic       sdata_from_adc, sdo_oe, sample_strobe, channel, sgl_diff, busy, abort;
  logic [9:0] sample_ch0 = '0, sample_ch1 = '0;

  adc_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .adc_sck(adc_sck), .adc_cs(adc_cs),
    .sdata_to_adc(sdata_to_adc), .sdata_from_adc(sdata_from_adc), .sdo_oe(sdo_oe),
    .sample_ch0(sample_ch0), .sample_ch1(sample_ch1), .sample_strobe(sample_strobe),
    .channel(channel), .sgl_diff(sgl_diff), .busy(busy), .abort(abort)
  );

  always #10 sysclk = ~sysclk;

  typedef struct {
    logic [9:0] data;
    logic [8:0] tail;
    logic       long_frame;
    logic       ch;
    logic       sgl;
  } exp_t;

  typedef struct {
    logic [19:0] bits;
    logic        oe_ok;
  } rx_t;

  exp_t exp_q[$];
  rx_t  rx_q[$];
  int   n_cmp = 0, n_err = 0;
  int   strobe_cnt = 0, abort_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic half_period();
    repeat (HALF) @(negedge sysclk);
  endtask

  // Header (leading zeros, start, SGL, ODD, MSBF), then ncyc read clocks; SCK is left high.
  task automatic spi_clocks(input logic sgl, input logic odd, input logic msbf,
                            input int lead0, input int ncyc,
                            output logic [19:0] rx, output logic oe_ok);
    logic [3:0] hdr;
    hdr   = {1'b1, sgl, odd, msbf};
    rx    = '0;
    oe_ok = 1'b1;
    adc_cs = 1'b0;
    half_period();
    for (int i = 0; i < lead0 + 4; i++) begin
      sdata_to_adc = (i < lead0) ? 1'b0 : hdr[3 - (i - lead0)];
      half_period();
      adc_sck = 1'b1;
      half_period();
      adc_sck = 1'b0;
    end
    sdata_to_adc = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      half_period();
      adc_sck = 1'b1;
      rx    = {rx[18:0], sdata_from_adc};
      oe_ok = oe_ok & sdo_oe;
      if (j < ncyc - 1) begin
        half_period();
        adc_sck = 1'b0;
      end
    end
  endtask

  task automatic finish_frame();
    half_period();
    adc_sck = 1'b0;
    half_period();
    adc_cs = 1'b1;
    repeat (20) @(negedge sysclk);
  endtask

  task automatic run_frame(input logic sgl, input logic odd, input logic msbf, input int lead0,
                           input int ncyc, input logic [9:0] data, input logic [8:0] tail);
    exp_t e;
    rx_t  r;
    e.data = data; e.tail = tail; e.long_frame = (ncyc > 11); e.ch = odd; e.sgl = sgl;
    exp_q.push_back(e);
    spi_clocks(sgl, odd, msbf, lead0, ncyc, r.bits, r.oe_ok);
    check("busy_in_frame", busy, 1);
    finish_frame();
    check("busy_after_frame", busy, 0);
    rx_q.push_back(r);
  endtask

  // Monitor: counts pulses and scores each captured frame against the queued expectation.
  initial begin
    exp_t e;
    rx_t  r;
    forever begin
      @(negedge sysclk);
      if (sample_strobe) strobe_cnt++;
      if (abort) abort_cnt++;
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard_underflow: frame captured with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          if (e.long_frame) begin
            check("null_bit", r.bits[19], 0);
            check("data_word", r.bits[18:9], e.data);
            check("tail_bits", r.bits[8:0], e.tail);
          end else begin
            check("null_bit", r.bits[10], 0);
            check("data_word", r.bits[9:0], e.data);
          end
          check("sdo_oe_during_read", r.oe_ok, 1);
          check("channel", channel, e.ch);
          check("sgl_diff", sgl_diff, e.sgl);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] rx;
    logic        ok;
    int          lat, abort_before;
    logic [8:0]  lsbf_tail;

    repeat (5) @(negedge sysclk);
    check("reset_outputs",
          {sdata_from_adc, sdo_oe, sample_strobe, channel, sgl_diff, busy, abort}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge sysclk);

    sample_ch1 = 10'h2A5;
    run_frame(1'b1, 1'b1, 1'b1, 0, 11, 10'h2A5, 9'h0);
    check("no_abort_full_frame", abort_cnt, 0);
    check("one_strobe_first_frame", strobe_cnt, 1);

    sample_ch0 = 10'h3FF;
    run_frame(1'b1, 1'b0, 1'b1, 0, 11, 10'h3FF, 9'h0);
    sample_ch0 = 10'h000;
    run_frame(1'b1, 1'b0, 1'b1, 0, 11, 10'h000, 9'h0);

    // Two leading zeros before the start bit, differential mode.
    sample_ch1 = 10'h1C3;
    run_frame(1'b0, 1'b1, 1'b1, 2, 11, 10'h1C3, 9'h0);

    // Abort after null + B9..B6 of 10'h2D4.
    sample_ch0   = 10'h2D4;
    abort_before = abort_cnt;
    spi_clocks(1'b1, 1'b0, 1'b1, 0, 5, rx, ok);
    check("abort_partial_bits", rx[4:0], 5'b01011);
    adc_cs = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge sysclk);
      if (!sdo_oe && lat == 0) lat = k;
    end
    check("abort_oe_latency", lat, SYNC_STAGES + 2);
    check("abort_pulse_once", abort_cnt - abort_before, 1);
    check("abort_busy_low", busy, 0);
    adc_sck = 1'b0;
    repeat (20) @(negedge sysclk);
    check("sck_ignored_cs_high", {sdo_oe, sdata_from_adc}, 0);

    sample_ch0 = 10'h0F0;
    run_frame(1'b1, 1'b0, 1'b1, 0, 11, 10'h0F0, 9'h0);

    // MSBF=0: B1..B9 of 10'h301 follow B0 only when the LSB-first tail is built in.
`ifdef ADC_RESP_LSBF_EN
    lsbf_tail = 9'b000000011;
`else
    lsbf_tail = 9'b000000000;
`endif
    sample_ch0 = 10'h301;
    run_frame(1'b1, 1'b0, 1'b0, 0, 20, 10'h301, lsbf_tail);

    // Reset during DATA after null + B9..B5 of 10'h0AA.
    sample_ch1 = 10'h0AA;
    spi_clocks(1'b1, 1'b1, 1'b1, 0, 6, rx, ok);
    check("pre_reset_bits", rx[5:0], 6'b000101);
    @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame_outputs",
          {sdata_from_adc, sdo_oe, sample_strobe, channel, sgl_diff, busy, abort}, 0);
    adc_sck = 1'b0;
    adc_cs  = 1'b1;
    repeat (10) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (10) @(negedge sysclk);

    sample_ch1 = 10'h35A;
    run_frame(1'b1, 1'b1, 1'b1, 0, 11, 10'h35A, 9'h0);

    repeat (20) @(negedge sysclk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("strobe_total", strobe_cnt, 9);
    check("abort_total", abort_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
